// File: rtl/tblink_rpc_ep_tx.sv
// tblink RPC endpoint network-output merger: forwarded packets and TIP packets (with inserted header) onto one byte stream.
// Define TBLINK_RPC_EP_TX_RR_EN for round-robin arbitration; default is fixed forward-first priority.
module tblink_rpc_ep_tx #(
   parameter logic [6:0] ADDR = 7'd1
) (
   input  logic       uclock,
   input  logic       reset,
   input  logic [6:0] dst_addr,
   input  logic [7:0] fwdi_dat,
   input  logic       fwdi_valid,
   output logic       fwdi_ready,
   input  logic [7:0] tipi_dat,
   input  logic       tipi_valid,
   output logic       tipi_ready,
   output logic [7:0] neto_dat,
   output logic       neto_valid,
   input  logic       neto_ready,
   output logic       drop_o,
   output logic       busy
);

   generate
      if (ADDR == 7'd0) begin : g_addr_check
         $fatal(1, "tblink_rpc_ep_tx: ADDR 0 is reserved");
      end
   endgenerate

   typedef enum logic [3:0] {
      IDLE, FWD_HDR, FWD_CNT, FWD_DATA, TIP_HDR, TIP_CNT, TIP_DATA, DRP_CNT, DRP_DATA
   } state_t;

   state_t      state, state_nxt;
   logic        ld_ok, fwd_acc, tip_acc, grant_fwd, grant_tip;
   logic        load, cnt_ld, cnt_dec, last_byte;
   logic [7:0]  load_dat, cnt_byte;
   logic [8:0]  rem;
   logic [6:0]  hdr_r;

   assign ld_ok     = !neto_valid || neto_ready;
   assign fwd_acc   = fwdi_valid && fwdi_ready;
   assign tip_acc   = tipi_valid && tipi_ready;
   assign last_byte = (rem == 9'd1);
   assign busy      = (state != IDLE);

`ifdef TBLINK_RPC_EP_TX_RR_EN
   // rr_last: 1 when TIP was granted most recently, so forward wins the first contention after reset
   logic rr_last;

   always_ff @(posedge uclock or posedge reset) begin
      if (reset)          rr_last <= 1'b1;
      else if (grant_fwd) rr_last <= 1'b0;
      else if (grant_tip) rr_last <= 1'b1;
   end
`endif

   always_comb begin
      grant_fwd = 1'b0;
      grant_tip = 1'b0;
      if (state == IDLE) begin
`ifdef TBLINK_RPC_EP_TX_RR_EN
         grant_fwd = fwdi_valid && (!tipi_valid || rr_last);
`else
         grant_fwd = fwdi_valid;
`endif
         grant_tip = tipi_valid && !grant_fwd;
      end
   end

   always_ff @(posedge uclock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_fwd)      state_nxt = FWD_HDR;
            else if (grant_tip) state_nxt = (dst_addr == 7'd0) ? DRP_CNT : TIP_HDR;
         end
         FWD_HDR:  if (fwd_acc) state_nxt = FWD_CNT;
         FWD_CNT:  if (fwd_acc) state_nxt = FWD_DATA;
         FWD_DATA: if (fwd_acc && last_byte) state_nxt = IDLE;
         TIP_HDR:  if (ld_ok) state_nxt = TIP_CNT;
         TIP_CNT:  if (tip_acc) state_nxt = TIP_DATA;
         TIP_DATA: if (tip_acc && last_byte) state_nxt = IDLE;
         DRP_CNT:  if (tip_acc) state_nxt = DRP_DATA;
         DRP_DATA: if (tip_acc && last_byte) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Only the granted source ever sees ready; the drop path swallows bytes without touching the output register
   always_comb begin
      fwdi_ready = 1'b0;
      tipi_ready = 1'b0;
      load       = 1'b0;
      load_dat   = fwdi_dat;
      case (state)
         FWD_HDR, FWD_CNT, FWD_DATA: begin
            fwdi_ready = ld_ok;
            load       = fwdi_valid && ld_ok;
         end
         TIP_HDR: begin
            load     = ld_ok;
            load_dat = {1'b0, hdr_r};
         end
         TIP_CNT, TIP_DATA: begin
            tipi_ready = ld_ok;
            load       = tipi_valid && ld_ok;
            load_dat   = tipi_dat;
         end
         DRP_CNT, DRP_DATA: tipi_ready = 1'b1;
         default: ;
      endcase
   end

   assign cnt_byte = (state == FWD_CNT) ? fwdi_dat : tipi_dat;
   assign cnt_ld   = ((state == FWD_CNT) && fwd_acc) ||
                     (((state == TIP_CNT) || (state == DRP_CNT)) && tip_acc);
   assign cnt_dec  = ((state == FWD_DATA) && fwd_acc) ||
                     (((state == TIP_DATA) || (state == DRP_DATA)) && tip_acc);

   // rem holds payload bytes still owed; the IDLE return on the last byte keeps it from underflowing
   always_ff @(posedge uclock or posedge reset) begin
      if (reset) begin
         neto_valid <= 1'b0;
         neto_dat   <= 8'h00;
         rem        <= 9'd0;
         hdr_r      <= 7'd0;
         drop_o     <= 1'b0;
      end else begin
         drop_o <= grant_tip && (dst_addr == 7'd0);
         if (grant_tip) hdr_r <= dst_addr;
         if (cnt_ld)       rem <= {1'b0, cnt_byte} + 9'd1;
         else if (cnt_dec) rem <= rem - 9'd1;
         if (load) begin
            neto_dat   <= load_dat;
            neto_valid <= 1'b1;
         end else if (neto_ready) begin
            neto_valid <= 1'b0;
         end
      end
   end

endmodule
